// File: rtl/relu_pipe_pkg.sv
// Shared constants and FSM encoding for the ReLU/shift/clip streaming pipeline.
package relu_pipe_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned CNT_BITS  = 10;
    localparam int unsigned CLIP_MAX  = 255;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } state_t;

endpackage

// File: rtl/relu_pipe_dp.sv
// Three-stage free-running datapath: register input, ReLU + logical right shift, 8-bit clip.
module relu_pipe_dp #(
    parameter int unsigned WORD_SIZE = relu_pipe_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic [3:0]           shift,
    input  logic                 clip_en,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_data
);
    import relu_pipe_pkg::CLIP_MAX;

    localparam logic [WORD_SIZE-1:0] ClipVal = WORD_SIZE'(CLIP_MAX);

    logic                 v1_q, v2_q, v3_q;
    logic [WORD_SIZE-1:0] d1_q, d2_q, d3_q;
    logic [WORD_SIZE-1:0] d2_d, d3_d;

    always_comb begin
        d2_d = '0;
        if (!d1_q[WORD_SIZE-1] && (32'(shift) < WORD_SIZE)) begin
            d2_d = d1_q >> shift;
        end
    end

    always_comb begin
        d3_d = d2_q;
        if (clip_en && (d2_q > ClipVal)) begin
            d3_d = ClipVal;
        end
    end

    // Data registers only load on valid so the output word holds between beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            d1_q <= '0;
            d2_q <= '0;
            d3_q <= '0;
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) d1_q <= in_data;
            if (v1_q)     d2_q <= d2_d;
            if (v2_q)     d3_q <= d3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_data  = d3_q;

endmodule

// File: rtl/relu_pipe.sv
// Frame-controlled ReLU pipeline: FSM and element counters around the relu_pipe_dp datapath.
module relu_pipe #(
    parameter int unsigned WORD_SIZE = relu_pipe_pkg::WORD_SIZE,
    parameter int unsigned CNT_BITS  = relu_pipe_pkg::CNT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_BITS-1:0]  n,
    input  logic [3:0]           cfg_shift,
    input  logic                 cfg_clip_en,
    input  logic                 DI_valid,
    input  logic [WORD_SIZE-1:0] DI,
    output logic                 DO_valid,
    output logic [WORD_SIZE-1:0] DO,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);
    import relu_pipe_pkg::*;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_BITS-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_BITS-1:0] n_lat_q;
    logic [3:0]          shift_lat_q;
    logic                clip_lat_q;
    logic                ovf_q;

    logic start, accept, last_in, last_out;

    always_comb begin
        start    = ((state_q == StIdle) || (state_q == StDone)) && DI_valid && (n != '0);
        accept   = start || ((state_q == StRun) && DI_valid);
        last_in  = (in_cnt_q + CNT_BITS'(1)) == n_lat_q;
        last_out = DO_valid && ((out_cnt_q + CNT_BITS'(1)) == n_lat_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A single-element frame is complete on its first beat, so it skips RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) state_d = (n == CNT_BITS'(1)) ? StFlush : StRun;
            end
            StRun: begin
                if (DI_valid && last_in) state_d = StFlush;
            end
            StFlush: begin
                if (last_out) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun) || (state_q == StFlush);
        done = (state_q == StDone);
        ovf  = ovf_q;
    end

    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (start) begin
            in_cnt_d  = CNT_BITS'(1);
            out_cnt_d = '0;
        end else begin
            if ((state_q == StRun) && DI_valid) in_cnt_d = in_cnt_q + CNT_BITS'(1);
            if (DO_valid) out_cnt_d = out_cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            n_lat_q     <= '0;
            shift_lat_q <= '0;
            clip_lat_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ovf_q     <= ovf_q | (DI_valid & ~accept);
            if (start) begin
                n_lat_q     <= n;
                shift_lat_q <= cfg_shift;
                clip_lat_q  <= cfg_clip_en;
            end
        end
    end

    relu_pipe_dp #(
        .WORD_SIZE (WORD_SIZE)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_data   (DI),
        .shift     (shift_lat_q),
        .clip_en   (clip_lat_q),
        .out_valid (DO_valid),
        .out_data  (DO)
    );

endmodule

// File: tb/tb_relu_pipe.sv
// Bench for relu_pipe: frame-level reference model, per-cycle compare, directed and random frames.
module tb_relu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  n = '0;
    logic [3:0]  cfg_shift = '0;
    logic        cfg_clip_en = 1'b0;
    logic        DI_valid = 1'b0;
    logic [15:0] DI = '0;
    logic        DO_valid;
    logic [15:0] DO;
    logic        busy, done, ovf;

    int n_tests = 0;
    int n_fail  = 0;

    relu_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .n           (n),
        .cfg_shift   (cfg_shift),
        .cfg_clip_en (cfg_clip_en),
        .DI_valid    (DI_valid),
        .DI          (DI),
        .DO_valid    (DO_valid),
        .DO          (DO),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_out(input logic [15:0] x, input int sh, input bit clip);
        int v;
        if (x[15]) v = 0;
        else       v = int'(x) / (1 << sh);
        if (clip && v > 255) v = 255;
        return v[15:0];
    endfunction

    // Reference model: frame bookkeeping in plain integers, expected outputs in a timed queue.
    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    bit          m_active = 0, m_done = 0, m_ovf = 0, was_active;
    int          m_nacc = 0, m_nout = 0, m_nlat = 0, m_shift = 0;
    bit          m_clip = 0;
    logic [15:0] m_hold = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_active = 0; m_done = 0; m_ovf = 0;
            m_nacc = 0; m_nout = 0; m_nlat = 0; m_shift = 0; m_clip = 0;
            m_hold = '0;
        end else begin
            cyc++;
            was_active = m_active;
            if (DI_valid) begin
                if (!was_active) begin
                    if (n != 0) begin
                        m_active = 1; m_done = 0;
                        m_nlat = int'(n); m_shift = int'(cfg_shift); m_clip = cfg_clip_en;
                        m_nacc = 1; m_nout = 0;
                        q.push_back('{cyc + 2, ref_out(DI, m_shift, m_clip)});
                    end else begin
                        m_ovf = 1;
                    end
                end else if (m_nacc < m_nlat) begin
                    m_nacc++;
                    q.push_back('{cyc + 2, ref_out(DI, m_shift, m_clip)});
                end else begin
                    m_ovf = 1;
                end
            end
            if (q.size() > 0 && q[0].due == cyc - 1) begin
                m_hold = q[0].val;
                void'(q.pop_front());
                m_nout++;
                if (m_nout == m_nlat) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
    end

    logic [15:0] seen[$];
    bit          exp_v;
    logic [15:0] exp_d;

    always @(negedge clk) begin
        if (rst) begin
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            exp_d = exp_v ? q[0].val : m_hold;
            check("do_valid", DO_valid, exp_v);
            check("do", DO, exp_d);
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("ovf", ovf, m_ovf);
            if (DO_valid) seen.push_back(DO);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [15:0] d);
        DI_valid = v;
        DI       = d;
        tick();
    endtask

    task automatic set_cfg(input int nn, input int sh, input bit clip);
        n           = 10'(nn);
        cfg_shift   = 4'(sh);
        cfg_clip_en = clip;
    endtask

    task automatic wait_done(input string name, input int budget);
        DI_valid = 1'b0;
        for (int i = 0; i < budget && !done; i++) tick();
        check(name, done, 1);
    endtask

    int base;

    initial begin
        tick();
        tick();
        check("rst_do_valid", DO_valid, 0);
        check("rst_do", DO, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b1;
        tick();

        // Back-to-back frame, signed inputs, no shift or clip.
        base = seen.size();
        set_cfg(4, 0, 0);
        drive(1, 16'hFFFB);
        drive(1, 16'd7);
        drive(1, 16'd0);
        check("t1_first_valid", DO_valid, 1);
        check("t1_first_data", DO, 0);
        drive(1, 16'h8000);
        check("t1_second_data", DO, 7);
        wait_done("t1_done", 10);
        check("t1_cnt", 32'(seen.size() - base), 4);
        check("t1_o2", seen[base + 2], 0);
        check("t1_o3", seen[base + 3], 0);

        // Gapped frame with shift and clip.
        base = seen.size();
        set_cfg(3, 2, 1);
        drive(1, 16'd1000);
        drive(0, 16'd0);
        drive(1, 16'd12);
        drive(0, 16'd0);
        drive(1, 16'hFFFF);
        wait_done("t2_done", 10);
        check("t2_cnt", 32'(seen.size() - base), 3);
        check("t2_o0", seen[base], 250);
        check("t2_o1", seen[base + 1], 3);
        check("t2_o2", seen[base + 2], 0);

        // Saturation at the 8-bit boundary.
        base = seen.size();
        set_cfg(2, 0, 1);
        drive(1, 16'd300);
        drive(1, 16'd255);
        wait_done("t3_done", 10);
        check("t3_o0", seen[base], 255);
        check("t3_o1", seen[base + 1], 255);

        // Extra beat during FLUSH is dropped and flagged.
        base = seen.size();
        set_cfg(2, 0, 0);
        drive(1, 16'd5);
        drive(1, 16'd6);
        drive(1, 16'd7);
        wait_done("t4_done", 10);
        check("t4_cnt", 32'(seen.size() - base), 2);
        check("t4_o1", seen[base + 1], 6);
        check("t4_ovf", ovf, 1);

        // Reset mid-frame aborts in-flight beats.
        set_cfg(5, 0, 0);
        drive(1, 16'd11);
        drive(1, 16'd12);
        drive(0, 16'd0);
        rst = 1'b0;
        #1;
        check("t5_do_valid", DO_valid, 0);
        check("t5_do", DO, 0);
        check("t5_busy", busy, 0);
        check("t5_ovf", ovf, 0);
        tick();
        rst = 1'b1;
        base = seen.size();
        repeat (5) tick();
        check("t5_no_out", 32'(seen.size() - base), 0);
        set_cfg(1, 0, 0);
        drive(1, 16'd9);
        wait_done("t5_done", 10);
        check("t5_o0", seen[base], 9);

        // Restart from DONE: done drops on the first beat.
        base = seen.size();
        set_cfg(2, 1, 0);
        drive(1, 16'd8);
        check("t6_done_low", done, 0);
        drive(1, 16'd6);
        wait_done("t6_done", 10);
        check("t6_o0", seen[base], 4);
        check("t6_o1", seen[base + 1], 3);

        // n==0 beat in DONE is dropped; state stays DONE.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_cfg(1, 0, 0);
        drive(1, 16'd1);
        wait_done("t7_pre", 10);
        set_cfg(0, 0, 0);
        drive(1, 16'd2);
        DI_valid = 1'b0;
        check("t7_done", done, 1);
        check("t7_ovf", ovf, 1);

        // Random frames with per-cycle random configuration and gaps.
        for (int f = 0; f < 30; f++) begin
            if (f % 10 == 5) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            for (int c = 0; c < 30; c++) begin
                set_cfg($urandom_range(0, 12), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
                drive($urandom_range(0, 3) != 0, 16'($urandom));
            end
            DI_valid = 1'b0;
            repeat (6) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/relu_pipe.md
RELU_PIPE -- requirements
Module: relu_pipe

Interface
REQ-001 Parameter WORD_SIZE, default 16, data word width; two's-complement signed.
REQ-002 Parameter CNT_BITS, default 10, element-counter width; matches n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 n  input  CNT_BITS  elements per frame; sampled on frame start.
REQ-006 cfg_shift  input  4  right-shift amount applied after ReLU; sampled on frame start.
REQ-007 cfg_clip_en  input  1  enables unsigned 8-bit saturation; sampled on frame start.
REQ-008 DI_valid  input  1  input beat qualifier; no backpressure exists.
REQ-009 DI  input  WORD_SIZE  input data word.
REQ-010 DO_valid  output  1  output beat qualifier.
REQ-011 DO  output  WORD_SIZE  result word.
REQ-012 busy  output  1  high in RUN or FLUSH.
REQ-013 done  output  1  level; high in DONE state.
REQ-014 ovf  output  1  sticky flag; beat arrived while not accepting.

Function
REQ-015 FSM states IDLE, RUN, FLUSH, DONE; reset state IDLE.
REQ-016 IDLE/DONE + DI_valid with n!=0 -> RUN; that beat is accepted; n, cfg_shift, cfg_clip_en latched that cycle; done clears that cycle.
REQ-017 IDLE/DONE + DI_valid with n==0 -> beat dropped, ovf set, state unchanged.
REQ-018 RUN: every DI_valid beat accepted, in_cnt increments; beat making in_cnt==n_lat -> FLUSH next cycle.
REQ-019 Gaps (DI_valid low) allowed in RUN; state and counters hold.
REQ-020 FLUSH/DONE-exempt: DI_valid in FLUSH is dropped, no DO_valid generated, ovf set.
REQ-021 FLUSH -> DONE the cycle after the out_cnt==n_lat beat leaves on DO_valid; done rises then.
REQ-022 Pipeline 3 stages, free-running; accepted beat at cycle t appears on DO_valid at t+3; back-to-back throughput 1 beat/cycle.
REQ-023 Stage 1 registers DI and valid.
REQ-024 Stage 2: x<0 -> 0, else x >> shift_lat (logical, input non-negative); shift>=WORD_SIZE yields 0.
REQ-025 Stage 3: clip_lat=1 and value>255 -> 255; else passthrough.
REQ-026 DO holds last value when DO_valid low; DO_valid high only for accepted beats.
REQ-027 out_cnt increments per DO_valid beat; both counters clear on frame start.
REQ-028 Simultaneous last output and new DI_valid in FLUSH: beat dropped, ovf set.
REQ-029 ovf clears only on reset.

Reset
REQ-030 rst low: state IDLE, DO_valid=0, DO=0, busy=0, done=0, ovf=0, counters 0, pipeline valids 0, latched cfg 0.
REQ-031 Reset mid-frame aborts immediately; in-flight beats discarded, no DO_valid after release until new accepted beat.

Structure
REQ-032 Shared package holds WORD_SIZE, CNT_BITS, CLIP_MAX=255, FSM state encoding.
REQ-033 One sub-module relu_pipe_dp: 3-stage datapath (valid+data); FSM and counters stay in relu_pipe.

Verification
REQ-034 n=4, cfg_shift=0, clip off, DI=-5,7,0,-32768 back-to-back -> DO_valid 4 beats starting 3 cycles later: 0,7,0,0; done high after 4th.
REQ-035 n=3, shift=2, clip on, DI=1000,12,-1 with 1-cycle gaps -> DO=250,3,0 at matching gaps; done=1.
REQ-036 n=2, clip on, shift=0, DI=300,255 -> DO=255,255.
REQ-037 n=2, three back-to-back beats -> 2 outputs, third dropped, ovf=1, done=1.
REQ-038 Reset asserted after 2 of n=5 beats -> all outputs 0 immediately, no DO_valid post-release; new frame n=1, DI=9 -> DO=9, done=1.
REQ-039 Frame 1 n=1 done, then frame 2 n=2 shift=1 DI=8,6 -> done drops on first beat, DO=4,3, done re-asserts.
